// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibits the bus, issues a request-to-send,
// clocks out D0..D7, odd parity and stop on device clock falls, then samples the ACK bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] TX_DATA,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DATA_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DATA_OE,
    output logic       BUSY,
    output logic       DONE,
    output logic       ACK_ERR,
    output logic       TO_ERR
);
    localparam int REQ_CYCLES = 16;
    localparam int MAX_AB     = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_MAX    = (MAX_AB > REQ_CYCLES) ? MAX_AB : REQ_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] REQ_LAST     = CNT_W'(REQ_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_WAIT_IDLE, S_FIN
    } state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~(^b);
    endfunction

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       bit_idx, bit_idx_n;
    logic [7:0]       tx_byte, tx_byte_n;
    logic             clk_oe_n, data_oe_n, ack_err_n, to_err_n;
    logic             clk_sync_p0, clk_sync_p1, clk_prev_p2;
    logic             data_sync_p0, data_sync_p1;
    logic             fall;
    logic [9:0]       frame;

    assign fall  = clk_prev_p2 & ~clk_sync_p1;
    assign frame = {1'b1, odd_parity(tx_byte), tx_byte};
    assign BUSY  = (state != S_IDLE);
    assign DONE  = (state == S_FIN);

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        tx_byte_n = tx_byte;
        clk_oe_n  = PS2_CLK_OE;
        data_oe_n = PS2_DATA_OE;
        ack_err_n = ACK_ERR;
        to_err_n  = TO_ERR;
        case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (START) begin
                    tx_byte_n = TX_DATA;
                    ack_err_n = 1'b0;
                    to_err_n  = 1'b0;
                    cnt_n     = '0;
                    clk_oe_n  = 1'b1;
                    state_n   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (cnt == INHIBIT_LAST) begin
                    cnt_n     = '0;
                    data_oe_n = 1'b1;
                    state_n   = S_REQ;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_REQ: begin
                // Releasing the clock while data stays low presents the start bit.
                if (cnt == REQ_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = 4'd0;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b1;
                    state_n   = S_SEND;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_SEND: begin
                if (fall) begin
                    cnt_n     = '0;
                    data_oe_n = ~frame[bit_idx];
                    if (bit_idx == 4'd9) state_n = S_ACK;
                    else                 bit_idx_n = bit_idx + 4'd1;
                end else if (cnt == TIMEOUT_LAST) begin
                    to_err_n  = 1'b1;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    state_n   = S_FIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_ACK: begin
                if (fall) begin
                    cnt_n     = '0;
                    ack_err_n = data_sync_p1;
                    state_n   = S_WAIT_IDLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    to_err_n  = 1'b1;
                    clk_oe_n  = 1'b0;
                    data_oe_n = 1'b0;
                    state_n   = S_FIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (clk_sync_p1 && data_sync_p1) begin
                    state_n = S_FIN;
                end else if (cnt == TIMEOUT_LAST) begin
                    to_err_n = 1'b1;
                    state_n  = S_FIN;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_FIN: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= 4'd0;
            tx_byte      <= 8'h00;
            PS2_CLK_OE   <= 1'b0;
            PS2_DATA_OE  <= 1'b0;
            ACK_ERR      <= 1'b0;
            TO_ERR       <= 1'b0;
            clk_sync_p0  <= 1'b1;
            clk_sync_p1  <= 1'b1;
            clk_prev_p2  <= 1'b1;
            data_sync_p0 <= 1'b1;
            data_sync_p1 <= 1'b1;
        end else begin
            // Pin synchronizers, then one extra clock stage for fall detection.
            clk_sync_p0  <= PS2_CLK_IN;
            clk_sync_p1  <= clk_sync_p0;
            clk_prev_p2  <= clk_sync_p1;
            data_sync_p0 <= PS2_DATA_IN;
            data_sync_p1 <= data_sync_p0;
            state        <= state_n;
            cnt          <= cnt_n;
            bit_idx      <= bit_idx_n;
            tx_byte      <= tx_byte_n;
            PS2_CLK_OE   <= clk_oe_n;
            PS2_DATA_OE  <= data_oe_n;
            ACK_ERR      <= ack_err_n;
            TO_ERR       <= to_err_n;
        end
    end

endmodule
